// File: rtl/resp_misr_monitor.sv
// Response MISR monitor: compacts accepted DUT samples into a 32-bit
// signature and sample count, then compares both against golden values.
module resp_misr_monitor #(
  parameter int          DATA_W = 16,
  parameter logic [31:0] SEED   = 32'h00000000,
  parameter logic [31:0] POLY   = 32'h00400007
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [DATA_W-1:0] resp_data,
  input  logic              resp_last,
  input  logic [31:0]       golden_sig,
  input  logic [31:0]       golden_cnt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [31:0]       signature,
  output logic [31:0]       sample_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  localparam int NS = (DATA_W + 31) / 32;

  state_t            state;
  logic [NS*32-1:0]  pad;
  logic [31:0]       fold;
  logic [31:0]       next_sig;
  logic              accept;

  // Zero-pad the sample to whole 32-bit slices and XOR-fold them.
  always_comb begin
    pad = '0;
    pad[DATA_W-1:0] = resp_data;
    fold = '0;
    for (int i = 0; i < NS; i++) begin
      fold = fold ^ pad[i*32 +: 32];
    end
  end

  assign resp_ready = (state == RUN);
  assign busy       = (state == RUN) || (state == CHECK);
  assign done       = (state == DONE);
  assign accept     = resp_ready && resp_valid;
  assign next_sig   = {signature[30:0], 1'b0}
                    ^ (signature[31] ? POLY : 32'h0)
                    ^ fold;

  // Run control, signature compaction, counting and the final compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      signature  <= SEED;
      sample_cnt <= '0;
      pass       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            signature  <= SEED;
            sample_cnt <= '0;
            pass       <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            signature <= next_sig;
            if (sample_cnt != 32'hFFFFFFFF)
              sample_cnt <= sample_cnt + 32'd1;
            if (resp_last)
              state <= CHECK;
          end
        end
        CHECK: begin
          pass  <= (signature == golden_sig) &&
                   (sample_cnt == golden_cnt);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resp_misr_monitor.sv
// Directed bench for resp_misr_monitor: basic run, mismatch, feedback,
// gaps, mid-run reset and restart from DONE.
module tb_resp_misr_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_last;
  logic [31:0] golden_sig;
  logic [31:0] golden_cnt;

  logic        resp_ready, busy, done, pass;
  logic [31:0] signature, sample_cnt;

  logic        f_ready, f_busy, f_done, f_pass;
  logic [31:0] f_sig, f_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  resp_misr_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .golden_sig (golden_sig),
    .golden_cnt (golden_cnt),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .sample_cnt (sample_cnt)
  );

  resp_misr_monitor #(.SEED(32'h80000000)) dut_fb (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp_valid (resp_valid),
    .resp_ready (f_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .golden_sig (golden_sig),
    .golden_cnt (golden_cnt),
    .busy       (f_busy),
    .done       (f_done),
    .pass       (f_pass),
    .signature  (f_sig),
    .sample_cnt (f_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string tag, input logic b, input logic r,
                     input logic d);
    chk({tag, "_busy"},  {31'd0, busy},       {31'd0, b});
    chk({tag, "_ready"}, {31'd0, resp_ready}, {31'd0, r});
    chk({tag, "_done"},  {31'd0, done},       {31'd0, d});
  endtask

  task automatic drive(input logic v, input logic [15:0] dt,
                       input logic l);
    resp_valid = v;
    resp_data  = dt;
    resp_last  = l;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    golden_sig = 32'd3; golden_cnt = 32'd2;
    #12;
    ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_sig",  signature,  32'h0);
    chk("rst_cnt",  sample_cnt, 32'h0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_fbsig", f_sig, 32'h80000000);

    // No accepts before start
    rst = 1'b0;
    drive(1'b1, 16'h00AA, 1'b1);
    tick(); tick();
    ctl("idle", 1'b0, 1'b0, 1'b0);
    chk("idle_cnt", sample_cnt, 32'h0);
    chk("idle_sig", signature,  32'h0);

    // Basic run: 1, 1(last) -> sig 3, cnt 2
    drive(1'b0, 16'h0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    ctl("run0", 1'b1, 1'b1, 1'b0);
    drive(1'b1, 16'h0001, 1'b0); tick();
    chk("b_sig1", signature,  32'h1);
    chk("b_cnt1", sample_cnt, 32'h1);
    drive(1'b1, 16'h0001, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b0);
    chk("b_sig2", signature,  32'h3);
    chk("b_cnt2", sample_cnt, 32'h2);
    ctl("check", 1'b1, 1'b0, 1'b0);
    tick();
    ctl("done", 1'b0, 1'b0, 1'b1);
    chk("b_pass", {31'd0, pass}, 32'd1);
    tick(); tick();
    chk("hold_sig",  signature,  32'h3);
    chk("hold_cnt",  sample_cnt, 32'h2);
    chk("hold_pass", {31'd0, pass}, 32'd1);
    ctl("hold", 1'b0, 1'b0, 1'b1);

    // Restart from DONE, mismatch on signature
    golden_sig = 32'h4;
    start = 1'b1; tick(); start = 1'b0;
    chk("rs_sig",  signature,  32'h0);
    chk("rs_cnt",  sample_cnt, 32'h0);
    chk("rs_pass", {31'd0, pass}, 32'd0);
    ctl("rs", 1'b1, 1'b1, 1'b0);
    drive(1'b1, 16'h0001, 1'b0); tick();
    drive(1'b1, 16'h0001, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b0); tick();
    chk("mm_sig_done", {31'd0, done}, 32'd1);
    chk("mm_sig_pass", {31'd0, pass}, 32'd0);

    // Mismatch on count
    golden_sig = 32'h3; golden_cnt = 32'd3;
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b1, 16'h0001, 1'b0); tick();
    drive(1'b1, 16'h0001, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b0); tick();
    chk("mm_cnt_done", {31'd0, done}, 32'd1);
    chk("mm_cnt_pass", {31'd0, pass}, 32'd0);

    // Zero data and feedback via SEED=0x80000000
    golden_sig = 32'h0; golden_cnt = 32'd1;
    start = 1'b1; tick(); start = 1'b0;
    chk("fb_seed", f_sig, 32'h80000000);
    drive(1'b1, 16'h0000, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b0);
    chk("fb_sig",  f_sig, 32'h00400007);
    chk("fb_cnt",  f_cnt, 32'h1);
    chk("z_sig",   signature, 32'h0);
    tick();
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_pass", {31'd0, pass}, 32'd1);

    // Gaps and start ignored in RUN: 5, gap, 2(last) -> sig 8, cnt 2
    golden_sig = 32'h8; golden_cnt = 32'd2;
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b1, 16'h0005, 1'b0); tick();
    chk("g_sig1", signature, 32'h5);
    drive(1'b0, 16'hFFFF, 1'b1); start = 1'b1; tick();
    start = 1'b0;
    chk("g_cnt_gap", sample_cnt, 32'h1);
    chk("g_sig_gap", signature,  32'h5);
    ctl("g_gap", 1'b1, 1'b1, 1'b0);
    drive(1'b1, 16'h0002, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b0);
    chk("g_cnt", sample_cnt, 32'h2);
    chk("g_sig", signature,  32'h8);
    tick();
    chk("g_pass", {31'd0, pass}, 32'd1);

    // Reset mid-run after 5 accepts
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0001, 1'b0); tick();
    end
    chk("mr_cnt5", sample_cnt, 32'h5);
    chk("mr_sig5", signature,  32'h1F);
    #1 rst = 1'b1;
    #1;
    ctl("mr_rst", 1'b0, 1'b0, 1'b0);
    chk("mr_sig", signature,  32'h0);
    chk("mr_cnt", sample_cnt, 32'h0);
    chk("mr_pass", {31'd0, pass}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    tick();
    chk("mr_idle_cnt", sample_cnt, 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b1, 16'h0007, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b0);
    chk("mr_new_cnt", sample_cnt, 32'h1);
    chk("mr_new_sig", signature,  32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
